// File: rtl/l2_mem_write_buffer_pkg.sv
// Shared definitions for the L2 posted write buffer.
// Holds drain FSM encoding, default bus widths and the doubleword offset width.
// No logic; imported by the top and the address matcher.
package l2_mem_write_buffer_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  // Low address bits that select a byte inside one doubleword; never compared.
  localparam int OFS_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } drain_state_t;

endpackage

// File: rtl/wb_addr_match.sv
// Per-entry doubleword tag comparator over the circular write buffer.
// Latency: combinational. Backpressure: none, pure lookup.
// Ports: valid/tags (entry state), cmp_tag (probe), head/count (occupied window),
//        lock_head (skip the draining head), match/hit/idx (youngest match).
module wb_addr_match
  import l2_mem_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ADDR_W_DEF - OFS_W
) (
  input  logic [DEPTH-1:0]                   valid,
  input  logic [DEPTH-1:0][TAG_W-1:0]        tags,
  input  logic [TAG_W-1:0]                   cmp_tag,
  input  logic [$clog2(DEPTH)-1:0]           head,
  input  logic [$clog2(DEPTH):0]             count,
  input  logic                               lock_head,
  output logic [DEPTH-1:0]                   match,
  output logic                               hit,
  output logic [$clog2(DEPTH)-1:0]           idx
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] slot;

  // Walk the occupied window oldest-to-youngest so the last match seen is
  // the youngest one.
  always_comb begin
    match = '0;
    hit   = 1'b0;
    idx   = '0;
    slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if ((k < int'(count)) && !(lock_head && (k == 0)) &&
          valid[slot] && (tags[slot] == cmp_tag)) begin
        match[slot] = 1'b1;
        hit         = 1'b1;
        idx         = slot;
      end
    end
  end

endmodule

// File: rtl/l2_mem_write_buffer.sv
// Posted write buffer from L2 to memory with coalescing and read forwarding.
// Latency: push visible in count next cycle, earliest mem_addrstb two cycles after push.
// Backpressure: registered wr_ready = (count < DEPTH); memory side waits on mem_stb.
// Ports: wr_* (L2 write-back in), rd_* (forwarding probe), mem_* (memory bus),
//        empty/count (status). Async active-high rst.
module l2_mem_write_buffer
  import l2_mem_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_hit,
  output logic [DATA_W-1:0]        rd_hit_data,
  output logic                     mem_addrstb,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_stb,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - OFS_W;

  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [DEPTH-1:0][DATA_W-1:0]  data_q, data_d;
  logic [PTR_W-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]              count_q, count_d;
  drain_state_t                  state_q, state_d;
  logic                          wr_ready_q, wr_ready_d;
  logic                          mem_addrstb_q, mem_addrstb_d;
  logic                          mem_we_q, mem_we_d;
  logic [TAG_W-1:0]              mem_tag_q, mem_tag_d;
  logic [DATA_W-1:0]             mem_data_q, mem_data_d;

  logic [DEPTH-1:0] wr_match_vec, rd_match_vec;
  logic             wr_hit;
  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic             push, coalesce, append, pop;
  logic             lint_unused;

  assign lint_unused = ^{wr_addr[OFS_W-1:0], rd_addr[OFS_W-1:0], wr_match_vec, rd_match_vec};

  // The head is locked once it leaves IDLE: its data is already on the bus.
  wb_addr_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_wr_match (
    .valid(valid_q), .tags(tag_q), .cmp_tag(wr_addr[ADDR_W-1:OFS_W]),
    .head(head_q), .count(count_q), .lock_head(state_q != ST_IDLE),
    .match(wr_match_vec), .hit(wr_hit), .idx(wr_idx)
  );

  wb_addr_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_rd_match (
    .valid(valid_q), .tags(tag_q), .cmp_tag(rd_addr[ADDR_W-1:OFS_W]),
    .head(head_q), .count(count_q), .lock_head(1'b0),
    .match(rd_match_vec), .hit(rd_hit), .idx(rd_idx)
  );

  assign rd_hit_data = rd_hit ? data_q[rd_idx] : '0;

  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    data_d        = data_q;
    head_d        = head_q;
    tail_d        = tail_q;
    state_d       = state_q;
    mem_addrstb_d = 1'b0;
    mem_we_d      = mem_we_q;
    mem_tag_d     = mem_tag_q;
    mem_data_d    = mem_data_q;

    push     = wr_valid && wr_ready_q;
    coalesce = push && wr_hit;
    append   = push && !wr_hit;
    pop      = (state_q == ST_WAIT_ACK) && mem_stb;

    if (coalesce) begin
      data_d[wr_idx] = wr_data;
    end
    // Append and pop never target the same slot: append needs count < DEPTH,
    // so tail == head only when the buffer is empty and nothing can pop.
    if (append) begin
      valid_d[tail_q] = 1'b1;
      tag_d[tail_q]   = wr_addr[ADDR_W-1:OFS_W];
      data_d[tail_q]  = wr_data;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    count_d    = count_q + CNT_W'(append) - CNT_W'(pop);
    wr_ready_d = count_d < CNT_W'(DEPTH);

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d       = ST_ISSUE;
          mem_addrstb_d = 1'b1;
          mem_we_d      = 1'b1;
          mem_tag_d     = tag_q[head_q];
          // A write coalescing into the head on this same edge is still
          // allowed (head not yet locked), so bypass its data to the bus.
          mem_data_d    = (coalesce && (wr_idx == head_q)) ? wr_data : data_q[head_q];
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (mem_stb) begin
          state_d  = ST_IDLE;
          mem_we_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      tag_q         <= '0;
      data_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      wr_ready_q    <= 1'b1;
      mem_addrstb_q <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_tag_q     <= '0;
      mem_data_q    <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      data_q        <= data_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      state_q       <= state_d;
      wr_ready_q    <= wr_ready_d;
      mem_addrstb_q <= mem_addrstb_d;
      mem_we_q      <= mem_we_d;
      mem_tag_q     <= mem_tag_d;
      mem_data_q    <= mem_data_d;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign mem_addrstb = mem_addrstb_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = {mem_tag_q, {OFS_W{1'b0}}};
  assign mem_data    = mem_data_q;
  assign count       = count_q;
  assign empty       = (count_q == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_l2_mem_write_buffer.sv
// Directed bench for the L2 posted write buffer.
// Inputs change 1ns after the rising edge; outputs are checked there too.
// Memory acknowledges are driven by hand to control transaction timing.
module tb_l2_mem_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_hit_data;
  logic              mem_addrstb;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_stb;
  logic              empty;
  logic [2:0]        count;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  l2_mem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_hit_data(rd_hit_data),
    .mem_addrstb(mem_addrstb), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_stb(mem_stb),
    .empty(empty), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stb(input string tag);
    int n;
    n = 0;
    while (!mem_addrstb && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_stb_seen"}, 64'(mem_addrstb), 64'd1);
  endtask

  // Waits for the strobe, checks the transaction, acks ack_dly cycles after it.
  task automatic drain(input string tag, input logic [31:0] a, input logic [63:0] d,
                       input int ack_dly);
    wait_stb(tag);
    chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
    chk({tag, "_data"}, mem_data, d);
    chk({tag, "_we"}, 64'(mem_we), 64'd1);
    step();
    chk({tag, "_stb_1cyc"}, 64'(mem_addrstb), 64'd0);
    repeat (ack_dly - 1) step();
    chk({tag, "_we_held"}, 64'(mem_we), 64'd1);
    chk({tag, "_addr_held"}, 64'(mem_addr), 64'(a));
    mem_stb = 1'b1;
    step();
    mem_stb = 1'b0;
    chk({tag, "_we_drop"}, 64'(mem_we), 64'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; mem_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_addrstb", 64'(mem_addrstb), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_data", mem_data, 64'd0);
    chk("rst_rd_hit", 64'(rd_hit), 64'd0);

    // Single write, ack two cycles after the strobe
    wr_valid = 1'b1; wr_addr = 32'h100; wr_data = 64'hA5A5_0000_0000_0001;
    step();
    wr_valid = 1'b0;
    chk("single_count", 64'(count), 64'd1);
    chk("single_no_early_stb", 64'(mem_addrstb), 64'd0);
    step();
    chk("single_stb", 64'(mem_addrstb), 64'd1);
    chk("single_addr", 64'(mem_addr), 64'h100);
    chk("single_data", mem_data, 64'hA5A5_0000_0000_0001);
    chk("single_we", 64'(mem_we), 64'd1);
    step();
    chk("single_stb_low", 64'(mem_addrstb), 64'd0);
    chk("single_we_wait", 64'(mem_we), 64'd1);
    step();
    chk("single_we_ack", 64'(mem_we), 64'd1);
    mem_stb = 1'b1;
    step();
    mem_stb = 1'b0;
    chk("single_count_done", 64'(count), 64'd0);
    chk("single_empty_done", 64'(empty), 64'd1);
    chk("single_we_done", 64'(mem_we), 64'd0);

    // Fill with memory stalled
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 32'(i * 8); wr_data = 64'(8'h11 * (i + 1));
      step();
    end
    chk("fill_count4", 64'(count), 64'd4);
    chk("fill_not_ready", 64'(wr_ready), 64'd0);
    wr_addr = 32'h20; wr_data = 64'h55;
    step();
    wr_valid = 1'b0;
    chk("fill_5th_refused", 64'(count), 64'd4);
    chk("fill_head_addr", 64'(mem_addr), 64'h0);
    chk("fill_head_data", mem_data, 64'h11);
    chk("fill_head_we", 64'(mem_we), 64'd1);
    mem_stb = 1'b1;
    step();
    mem_stb = 1'b0;
    chk("fill_ready_after_ack", 64'(wr_ready), 64'd1);
    chk("fill_count3", 64'(count), 64'd3);
    drain("fill_e1", 32'h008, 64'h22, 1);
    drain("fill_e2", 32'h010, 64'h33, 3);
    drain("fill_e3", 32'h018, 64'h44, 1);
    chk("fill_empty", 64'(empty), 64'd1);

    // Coalesce behind a draining head, then a write to the locked head
    wr_valid = 1'b1; wr_addr = 32'h200; wr_data = 64'd1;
    step();
    wr_addr = 32'h208; wr_data = 64'd2;
    step();
    chk("coal_stb", 64'(mem_addrstb), 64'd1);
    chk("coal_head_addr", 64'(mem_addr), 64'h200);
    chk("coal_count2", 64'(count), 64'd2);
    wr_addr = 32'h208; wr_data = 64'd3;
    step();
    wr_valid = 1'b0;
    chk("coal_merge_count", 64'(count), 64'd2);
    chk("coal_head_data", mem_data, 64'd1);
    wr_valid = 1'b1; wr_addr = 32'h200; wr_data = 64'd4; mem_stb = 1'b1;
    step();
    wr_valid = 1'b0; mem_stb = 1'b0;
    chk("coal_locked_append", 64'(count), 64'd2);
    drain("coal_208", 32'h208, 64'd3, 1);
    drain("coal_200", 32'h200, 64'd4, 2);
    chk("coal_empty", 64'(empty), 64'd1);

    // Forwarding with a locked head and a younger coalesced entry
    wr_valid = 1'b1; wr_addr = 32'h300; wr_data = 64'd5;
    step();
    wr_valid = 1'b0;
    rd_addr = 32'h300;
    #1;
    chk("fwd_head_hit", 64'(rd_hit), 64'd1);
    chk("fwd_head_data", rd_hit_data, 64'd5);
    step();
    chk("fwd_issue", 64'(mem_addrstb), 64'd1);
    wr_valid = 1'b1; wr_addr = 32'h300; wr_data = 64'd7;
    step();
    wr_data = 64'd9;
    step();
    wr_valid = 1'b0;
    chk("fwd_count", 64'(count), 64'd2);
    rd_addr = 32'h304;
    #1;
    chk("fwd_hit", 64'(rd_hit), 64'd1);
    chk("fwd_youngest", rd_hit_data, 64'd9);
    rd_addr = 32'h400;
    #1;
    chk("fwd_miss", 64'(rd_hit), 64'd0);
    chk("fwd_miss_data", rd_hit_data, 64'd0);
    chk("fwd_head_locked", mem_data, 64'd5);
    mem_stb = 1'b1;
    step();
    mem_stb = 1'b0;
    drain("fwd_second", 32'h300, 64'd9, 1);
    rd_addr = 32'h300;
    #1;
    chk("fwd_gone", 64'(rd_hit), 64'd0);

    // Wrap-around with push and pop in the same cycle at count 2
    for (int j = 0; j < 2; j++) begin
      wr_valid = 1'b1; wr_addr = 32'h1000 + 32'(8 * j); wr_data = 64'hD000 + 64'(j);
      step();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_stb("wrap");
      chk("wrap_addr", 64'(mem_addr), 64'h1000 + 64'(8 * i));
      chk("wrap_data", mem_data, 64'hD000 + 64'(i));
      step();
      wr_valid = 1'b1; wr_addr = 32'h1000 + 32'(8 * (i + 2)); wr_data = 64'hD000 + 64'(i + 2);
      mem_stb = 1'b1;
      step();
      wr_valid = 1'b0; mem_stb = 1'b0;
      chk("wrap_count", 64'(count), 64'd2);
    end
    drain("wrap_tail0", 32'h1050, 64'hD00A, 1);
    drain("wrap_tail1", 32'h1058, 64'hD00B, 1);
    chk("wrap_empty", 64'(empty), 64'd1);

    // Reset in the middle of a transaction
    for (int j = 0; j < 3; j++) begin
      wr_valid = 1'b1; wr_addr = 32'h500 + 32'(8 * j); wr_data = 64'hE0 + 64'(j);
      step();
    end
    wr_valid = 1'b0;
    chk("mrst_count3", 64'(count), 64'd3);
    chk("mrst_wait_we", 64'(mem_we), 64'd1);
    chk("mrst_wait_stb", 64'(mem_addrstb), 64'd0);
    rst = 1'b1;
    #1;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_ready", 64'(wr_ready), 64'd1);
    chk("mrst_empty", 64'(empty), 64'd1);
    chk("mrst_stb", 64'(mem_addrstb), 64'd0);
    chk("mrst_we", 64'(mem_we), 64'd0);
    chk("mrst_addr", 64'(mem_addr), 64'd0);
    chk("mrst_data", mem_data, 64'd0);
    rd_addr = 32'h500;
    #1;
    chk("mrst_rd_hit", 64'(rd_hit), 64'd0);
    step();
    step();
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      step();
      if (mem_addrstb) seen++;
    end
    chk("mrst_no_stb", 64'(seen), 64'd0);
    chk("mrst_still_empty", 64'(empty), 64'd1);
    wr_valid = 1'b1; wr_addr = 32'h600; wr_data = 64'hF1;
    step();
    wr_valid = 1'b0;
    drain("mrst_new", 32'h600, 64'hF1, 1);
    chk("mrst_final_empty", 64'(empty), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
